// File: rtl/hue_div_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency hue divider.
// Define HUE_ARB_STATS_EN to add the grant/stall statistics outputs.
module hue_div_arbiter #(
  parameter int DIVIDE_LATENCY = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [8:0]  i_req0_dividend,
  input  logic [8:0]  i_req0_divisor,
  input  logic [1:0]  i_req0_function,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [8:0]  i_req1_dividend,
  input  logic [8:0]  i_req1_divisor,
  input  logic [1:0]  i_req1_function,
  output logic        o_req1_ready,
  output logic [8:0]  o_div_dividend,
  output logic [8:0]  o_div_divisor,
  output logic [1:0]  o_div_function,
  output logic        o_div_valid,
  input  logic [15:0] i_div_data,
  input  logic [1:0]  i_div_function,
  input  logic        i_div_valid,
  output logic [15:0] o_res0_data,
  output logic [1:0]  o_res0_function,
  output logic        o_res0_valid,
  output logic [15:0] o_res1_data,
  output logic [1:0]  o_res1_function,
  output logic        o_res1_valid,
  input  logic        i_flush,
  output logic        o_idle,
  output logic        o_err
`ifdef HUE_ARB_STATS_EN
  ,
  output logic [31:0] o_stat_issue0,
  output logic [31:0] o_stat_issue1,
  output logic [31:0] o_stat_stall
`endif
);
  // state | meaning
  // RUN   | arbitrating and issuing to the divider
  // DRAIN | flush seen; issue blocked until in-flight results return
  // HOLD  | drained; waiting for i_flush to drop
  localparam int NUM_REQ = 2;
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [4:0] MAX_INFLIGHT = 5'(DIVIDE_LATENCY);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                    state;
  logic                      ptr;
  logic [4:0]                inflight;
  logic                      err;
  logic [DIVIDE_LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]           tag_id [DIVIDE_LATENCY];

  logic            run_ok;
  logic            grant0;
  logic            grant1;
  logic            issue;
  logic [ID_W-1:0] grant_id;
  logic            tail_valid;
  logic [ID_W-1:0] tail_id;
  logic            route;
  logic            mismatch;

  always_comb begin
    run_ok = (state == S_RUN) && !i_rst;
    grant0 = run_ok && i_req0_valid && (!i_req1_valid || !ptr);
    grant1 = run_ok && i_req1_valid && (!i_req0_valid || ptr);
  end

  assign issue        = grant0 || grant1;
  assign grant_id     = ID_W'(grant1);
  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_comb begin
    o_div_dividend = '0;
    o_div_divisor  = '0;
    o_div_function = '0;
    o_div_valid    = 1'b0;
    if (grant0) begin
      o_div_dividend = i_req0_dividend;
      o_div_divisor  = i_req0_divisor;
      o_div_function = i_req0_function;
      o_div_valid    = 1'b1;
    end else if (grant1) begin
      o_div_dividend = i_req1_dividend;
      o_div_divisor  = i_req1_divisor;
      o_div_function = i_req1_function;
      o_div_valid    = 1'b1;
    end
  end

  assign tail_valid = tag_valid[DIVIDE_LATENCY-1];
  assign tail_id    = tag_id[DIVIDE_LATENCY-1];
  assign route      = !i_rst && i_div_valid && tail_valid;
  assign mismatch   = i_div_valid != tail_valid;

  // A mismatch can never route: either no result or no matching tag.
  always_comb begin
    o_res0_data     = '0;
    o_res0_function = '0;
    o_res0_valid    = 1'b0;
    o_res1_data     = '0;
    o_res1_function = '0;
    o_res1_valid    = 1'b0;
    if (route && (tail_id == ID_W'(0))) begin
      o_res0_data     = i_div_data;
      o_res0_function = i_div_function;
      o_res0_valid    = 1'b1;
    end else if (route) begin
      o_res1_data     = i_div_data;
      o_res1_function = i_div_function;
      o_res1_valid    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_RUN;
      ptr       <= 1'b0;
      inflight  <= '0;
      err       <= 1'b0;
      tag_valid <= '0;
      for (int k = 0; k < DIVIDE_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_valid <= {tag_valid[DIVIDE_LATENCY-2:0], o_div_valid};
      for (int k = DIVIDE_LATENCY - 1; k > 0; k--) tag_id[k] <= tag_id[k-1];
      tag_id[0] <= grant_id;

      if (grant0) ptr <= 1'b1;
      else if (grant1) ptr <= 1'b0;

      if (mismatch) err <= 1'b1;

      case ({issue, route})
        2'b10: if (inflight != MAX_INFLIGHT) inflight <= inflight + 5'd1;
        2'b01: if (inflight != 5'd0) inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase

      case (state)
        S_RUN:   if (i_flush) state <= S_DRAIN;
        S_DRAIN: if (inflight == 5'd0) state <= S_HOLD;
        S_HOLD:  if (!i_flush) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  assign o_err  = err;
  assign o_idle = (state == S_RUN) && (inflight == 5'd0);

`ifdef HUE_ARB_STATS_EN
  logic stall;
  assign stall = (i_req0_valid && !grant0) || (i_req1_valid && !grant1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_issue0 <= '0;
      o_stat_issue1 <= '0;
      o_stat_stall  <= '0;
    end else begin
      if (grant0) o_stat_issue0 <= o_stat_issue0 + 32'd1;
      if (grant1) o_stat_issue1 <= o_stat_issue1 + 32'd1;
      if (stall)  o_stat_stall  <= o_stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hue_div_arbiter.sv
// Directed bench for hue_div_arbiter; the bench itself plays the fixed-latency divider.
// Scoreboard entries are pushed on predicted grants and popped when the result is due.
module tb_hue_div_arbiter;
  localparam int L = 16;

  typedef struct packed {
    logic        v;
    logic        id;
    logic [15:0] data;
    logic [1:0]  func;
  } ent_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic [8:0]  i_req0_dividend, i_req1_dividend, i_req0_divisor, i_req1_divisor;
  logic [1:0]  i_req0_function, i_req1_function;
  logic        o_req0_ready, o_req1_ready;
  logic [8:0]  o_div_dividend, o_div_divisor;
  logic [1:0]  o_div_function;
  logic        o_div_valid;
  logic [15:0] i_div_data;
  logic [1:0]  i_div_function;
  logic        i_div_valid;
  logic [15:0] o_res0_data, o_res1_data;
  logic [1:0]  o_res0_function, o_res1_function;
  logic        o_res0_valid, o_res1_valid;
  logic        i_flush, o_idle, o_err;
`ifdef HUE_ARB_STATS_EN
  logic [31:0] o_stat_issue0, o_stat_issue1, o_stat_stall;
`endif

  hue_div_arbiter #(.DIVIDE_LATENCY(L)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .i_req0_dividend(i_req0_dividend),
    .i_req0_divisor(i_req0_divisor), .i_req0_function(i_req0_function),
    .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_dividend(i_req1_dividend),
    .i_req1_divisor(i_req1_divisor), .i_req1_function(i_req1_function),
    .o_req1_ready(o_req1_ready),
    .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .o_div_function(o_div_function), .o_div_valid(o_div_valid),
    .i_div_data(i_div_data), .i_div_function(i_div_function), .i_div_valid(i_div_valid),
    .o_res0_data(o_res0_data), .o_res0_function(o_res0_function), .o_res0_valid(o_res0_valid),
    .o_res1_data(o_res1_data), .o_res1_function(o_res1_function), .o_res1_valid(o_res1_valid),
    .i_flush(i_flush), .o_idle(o_idle), .o_err(o_err)
`ifdef HUE_ARB_STATS_EN
    , .o_stat_issue0(o_stat_issue0), .o_stat_issue1(o_stat_issue1), .o_stat_stall(o_stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  ent_t dq[$];
  int   mst;
  logic mptr, merr;
  int   minf;
  logic [31:0] ms0, ms1, mstall;
  logic hold_ops = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pipe();
    dq.delete();
    for (int k = 0; k < L; k++) dq.push_back('0);
  endtask

  function automatic logic [15:0] div_fn(input logic [8:0] dd, input logic [8:0] dv);
    return {dd, dv[6:0]} ^ 16'h3c5a;
  endfunction

  task automatic do_cycle(input logic v0, input logic v1, input logic fl, input logic inj);
    ent_t fr, nw;
    logic g0, g1, run, route, dv;
    logic [8:0] edd, edv;
    logic [1:0] efn;
    int nst;
    if (!hold_ops) begin
      i_req0_dividend = 9'($urandom); i_req0_divisor = 9'($urandom); i_req0_function = 2'($urandom);
      i_req1_dividend = 9'($urandom); i_req1_divisor = 9'($urandom); i_req1_function = 2'($urandom);
    end
    i_req0_valid = v0;
    i_req1_valid = v1;
    i_flush = fl;
    fr = dq.pop_front();
    dv = fr.v | inj;
    i_div_valid = dv;
    i_div_data = inj ? 16'hdead : fr.data;
    i_div_function = inj ? 2'd3 : fr.func;
    run = (mst == 0) && !i_rst;
    g0 = run && v0 && (!v1 || !mptr);
    g1 = run && v1 && (!v0 || mptr);
    route = !i_rst && dv && fr.v;
    edd = g0 ? i_req0_dividend : (g1 ? i_req1_dividend : 9'd0);
    edv = g0 ? i_req0_divisor : (g1 ? i_req1_divisor : 9'd0);
    efn = g0 ? i_req0_function : (g1 ? i_req1_function : 2'd0);
    #1;
    chk("ready0", o_req0_ready, g0);
    chk("ready1", o_req1_ready, g1);
    chk("div_valid", o_div_valid, g0 | g1);
    chk("div_dividend", o_div_dividend, edd);
    chk("div_divisor", o_div_divisor, edv);
    chk("div_function", o_div_function, efn);
    chk("res0_valid", o_res0_valid, route && !fr.id);
    chk("res0_data", o_res0_data, (route && !fr.id) ? fr.data : 16'd0);
    chk("res0_function", o_res0_function, (route && !fr.id) ? fr.func : 2'd0);
    chk("res1_valid", o_res1_valid, route && fr.id);
    chk("res1_data", o_res1_data, (route && fr.id) ? fr.data : 16'd0);
    chk("res1_function", o_res1_function, (route && fr.id) ? fr.func : 2'd0);
    if (!i_rst) begin
      chk("err", o_err, merr);
      chk("idle", o_idle, (mst == 0) && (minf == 0));
      chk("inflight", 32'(dut.inflight), minf);
`ifdef HUE_ARB_STATS_EN
      chk("stat_issue0", o_stat_issue0, ms0);
      chk("stat_issue1", o_stat_issue1, ms1);
      chk("stat_stall", o_stat_stall, mstall);
`endif
    end
    nw.v = g0 | g1;
    nw.id = g1;
    nw.data = (g0 | g1) ? div_fn(edd, edv) : 16'd0;
    nw.func = efn;
    dq.push_back(nw);
    @(posedge clk);
    if (i_rst) begin
      mst = 0; mptr = 1'b0; minf = 0; merr = 1'b0;
      ms0 = '0; ms1 = '0; mstall = '0;
      clear_pipe();
    end else begin
      if (g0) mptr = 1'b1;
      else if (g1) mptr = 1'b0;
      if (dv != fr.v) merr = 1'b1;
      nst = mst;
      case (mst)
        0: if (fl) nst = 1;
        1: if (minf == 0) nst = 2;
        default: if (!fl) nst = 0;
      endcase
      mst = nst;
      if ((g0 | g1) && !route) minf = (minf == L) ? L : minf + 1;
      else if (route && !(g0 | g1)) minf = (minf == 0) ? 0 : minf - 1;
      if (g0) ms0 = ms0 + 32'd1;
      if (g1) ms1 = ms1 + 32'd1;
      if ((v0 && !g0) || (v1 && !g1)) mstall = mstall + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_div_valid = 1'b0; i_div_data = '0; i_div_function = '0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    mst = 0; mptr = 1'b0; minf = 0; merr = 1'b0; ms0 = '0; ms1 = '0; mstall = '0;
    clear_pipe();

    do_reset();
    do_reset();

    // Contention right after reset: grants alternate 0,1,0,1 then 3 more contention cycles.
    for (int k = 0; k < 7; k++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(L + 4);

    // Directed operand set from requester 0 only.
    hold_ops = 1'b1;
    i_req0_dividend = 9'h1F0; i_req0_divisor = 9'h020; i_req0_function = 2'd2;
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    hold_ops = 1'b0;
    idle_cycles(L + 2);

    // Three in flight, one-cycle flush, requesters keep asking during DRAIN.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(L + 4);

    // Flush arriving together with a grant: that grant still issues.
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cycles(L + 4);

    // Lone requester 1 for 20 cycles: in-flight count climbs to 16 and stays.
    for (int k = 0; k < 20; k++) do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(L + 4);

    // Mixed traffic.
    for (int k = 0; k < 40; k++) do_cycle(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    idle_cycles(L + 4);

    // Spurious divider result just after reset: sticky error, nothing routed.
    do_reset();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(L + 2);
    do_reset();
    idle_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
